dmem_responder: RTL and testbench

Data-side memory responder for the Mini-RISC-V pipeline. It sits at the far end of the MEM-stage memory port: it accepts the stage's read/write strobes, byte-lane enables, address and store data, and returns load data one cycle later. It contains the data RAM with byte-lane writes and a small MMIO window for the UART: a TX byte FIFO, an RX holding register and a status register. It asserts `mem_hold` to stall the MEM/WB register while a UART store cannot be accepted.

---
 rtl/dmem_responder_if.sv | 32 +++
 rtl/dmem_responder.sv | 173 +++++++++++++++++
 tb/tb_dmem_responder.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// MEM-stage data port plus UART byte streams between the pipeline/UART and
// the data-side memory responder.
interface dmem_responder_if;
  logic        mem_wea;
  logic        mem_rea;
  logic [3:0]  mem_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        mem_hold;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;

  modport master (
    output mem_wea, mem_rea, mem_en, mem_addr, mem_din,
    input  mem_dout, mem_hold,
    input  tx_data, tx_valid,
    output tx_ready,
    output rx_data, rx_valid
  );

  modport slave (
    input  mem_wea, mem_rea, mem_en, mem_addr, mem_din,
    output mem_dout, mem_hold,
    output tx_data, tx_valid,
    input  tx_ready,
    input  rx_data, rx_valid
  );
endinterface

// File: rtl/dmem_responder.sv
// Data RAM with byte-lane writes plus a UART MMIO window (TX FIFO, RX holding
// register, status); load data returns one cycle after the request.
module dmem_responder #(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
  parameter int          TX_DEPTH  = 8
) (
  input logic             clk,
  input logic             Rst,
  dmem_responder_if.slave bus
);
  localparam int         RAM_WORDS  = 2 ** ADDR_W;
  localparam int         TX_PTR_W   = $clog2(TX_DEPTH);
  localparam int         TX_CNT_W   = TX_PTR_W + 1;
  localparam logic [7:0] OFF_TXDATA = 8'h00;
  localparam logic [7:0] OFF_RXDATA = 8'h04;
  localparam logic [7:0] OFF_STATUS = 8'h08;

  typedef enum logic {SRC_MMIO, SRC_RAM} rd_src_e;

  logic [TX_PTR_W-1:0] r_tx_wptr;
  logic [TX_PTR_W-1:0] r_tx_rptr;
  logic [TX_CNT_W-1:0] r_tx_count;
  logic [7:0]          r_tx_mem [TX_DEPTH];
  logic [7:0]          r_rx_buf;
  logic                r_rx_full;
  logic                r_rx_overrun;
  logic [31:0]         r_ram [RAM_WORDS];
  logic [31:0]         r_ram_rd;
  logic [31:0]         r_mmio_rd;
  rd_src_e             r_rd_src;

  logic              w_is_mmio;
  logic [7:0]        w_off;
  logic              w_sel_tx;
  logic              w_sel_rx;
  logic              w_sel_status;
  logic [ADDR_W-1:0] w_word_idx;
  logic [1:0]        w_byte_off;
  logic              w_tx_full;
  logic              w_tx_empty;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_ram_wr;
  logic              w_ram_rd;
  logic              w_tx_push;
  logic              w_tx_pop;
  logic              w_rx_rd;
  logic              w_rx_take;
  logic              w_rx_overrun_ev;
  logic              w_overrun_clr;
  logic [31:0]       w_din_rot;
  logic [31:0]       w_mmio_rdata;

  // Address decode: anything outside the 256-byte window is RAM.
  assign w_is_mmio    = (bus.mem_addr[31:8] == MMIO_BASE[31:8]);
  assign w_off        = bus.mem_addr[7:0];
  assign w_sel_tx     = w_is_mmio && (w_off == OFF_TXDATA);
  assign w_sel_rx     = w_is_mmio && (w_off == OFF_RXDATA);
  assign w_sel_status = w_is_mmio && (w_off == OFF_STATUS);
  assign w_word_idx   = bus.mem_addr[ADDR_W+1:2];
  assign w_byte_off   = bus.mem_addr[1:0];

  assign w_tx_full  = (r_tx_count == TX_CNT_W'(TX_DEPTH));
  assign w_tx_empty = (r_tx_count == '0);

  // Only a TXDATA store into a full FIFO stalls; the whole request waits.
  assign bus.mem_hold = bus.mem_wea && w_sel_tx && w_tx_full;
  assign w_wr_acc     = bus.mem_wea && !bus.mem_hold;
  assign w_rd_acc     = bus.mem_rea && !bus.mem_hold;

  assign w_ram_wr  = w_wr_acc && !w_is_mmio;
  assign w_ram_rd  = w_rd_acc && !w_is_mmio;
  assign w_tx_push = w_wr_acc && w_sel_tx;
  assign w_tx_pop  = bus.tx_valid && bus.tx_ready;

  // Store data arrives in the low bits; move it onto the lanes mem_en selects.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    w_din_rot = bus.mem_din;
    case (w_byte_off)
      2'd0: w_din_rot = bus.mem_din;
      2'd1: w_din_rot = {bus.mem_din[23:0], bus.mem_din[31:24]};
      2'd2: w_din_rot = {bus.mem_din[15:0], bus.mem_din[31:16]};
      2'd3: w_din_rot = {bus.mem_din[7:0],  bus.mem_din[31:8]};
      default: w_din_rot = bus.mem_din;
    endcase
  end

  // NOTE: the data RAM has no reset so it maps onto block RAM; software initialises it.
  always_ff @(posedge clk) begin
    if (w_ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.mem_en[i]) r_ram[w_word_idx][8*i +: 8] <= w_din_rot[8*i +: 8];
      end
    end
    // NOTE: non-blocking assignments make the read see the pre-write word (read-first).
    if (w_ram_rd) r_ram_rd <= r_ram[w_word_idx];
  end

  always_comb begin
    w_mmio_rdata = '0;
    if (w_sel_rx) begin
      w_mmio_rdata = {24'h0, r_rx_buf};
    end else if (w_sel_status) begin
      w_mmio_rdata = {28'h0, r_rx_overrun, r_rx_full, w_tx_empty, w_tx_full};
    end
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_rd_src  <= SRC_MMIO;
      r_mmio_rd <= '0;
    end else if (w_rd_acc) begin
      r_rd_src <= w_is_mmio ? SRC_MMIO : SRC_RAM;
      if (w_is_mmio) r_mmio_rd <= w_mmio_rdata;
    end
  end

  // Both sources are registers; the mux only picks which one the last read loaded.
  assign bus.mem_dout = (r_rd_src == SRC_RAM) ? r_ram_rd : r_mmio_rd;

  // TX FIFO storage is cleared so the head byte reads 0 out of reset.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < TX_DEPTH; i++) r_tx_mem[i] <= '0;
      r_tx_wptr  <= '0;
      r_tx_rptr  <= '0;
      r_tx_count <= '0;
    end else begin
      if (w_tx_push) begin
        r_tx_mem[r_tx_wptr] <= bus.mem_din[7:0];
        r_tx_wptr           <= r_tx_wptr + 1'b1;
      end
      if (w_tx_pop) r_tx_rptr <= r_tx_rptr + 1'b1;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_count <= r_tx_count + 1'b1;
        2'b01:   r_tx_count <= r_tx_count - 1'b1;
        default: r_tx_count <= r_tx_count;
      endcase
    end
  end

  assign bus.tx_valid = !w_tx_empty;
  assign bus.tx_data  = r_tx_mem[r_tx_rptr];

  // A byte arriving while RXDATA is read replaces the one being returned.
  assign w_rx_rd         = w_rd_acc && w_sel_rx;
  assign w_rx_take       = bus.rx_valid && (!r_rx_full || w_rx_rd);
  assign w_rx_overrun_ev = bus.rx_valid && !w_rx_take;
  assign w_overrun_clr   = w_wr_acc && w_sel_status && bus.mem_din[3];

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_rx_buf     <= '0;
      r_rx_full    <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else begin
      if (w_rx_take) begin
        r_rx_buf  <= bus.rx_data;
        r_rx_full <= 1'b1;
      end else if (w_rx_rd) begin
        r_rx_full <= 1'b0;
      end
      // A fresh overrun wins over a software clear in the same cycle.
      if (w_rx_overrun_ev) begin
        r_rx_overrun <= 1'b1;
      end else if (w_overrun_clr) begin
        r_rx_overrun <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a behavioural model predicts load data,
// stalls and the TX byte stream; a monitor compares whatever the DUT presents.
module tb_dmem_responder;
  localparam int          ADDR_W   = 12;
  localparam int          TX_DEPTH = 8;
  localparam logic [31:0] MMIO     = 32'h8000_0000;

  logic clk = 1'b0;
  logic Rst = 1'b1;

  dmem_responder_if bus();

  dmem_responder #(.ADDR_W(ADDR_W), .MMIO_BASE(MMIO), .TX_DEPTH(TX_DEPTH)) dut (
    .clk (clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] m_ram [int];
  int          m_tx_cnt = 0;
  logic [7:0]  m_rx_buf = '0;
  bit          m_rx_full = 0;
  bit          m_rx_ovr = 0;
  bit          rand_mode = 0;

  // Scoreboard queues: expected load words and expected TX byte stream
  logic [31:0] rd_q[$];
  logic [7:0]  sb_tx[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit in_mmio(input logic [31:0] addr);
    return addr[31:8] == MMIO[31:8];
  endfunction

  function automatic int word_idx(input logic [31:0] addr);
    return int'(addr >> 2) % (1 << ADDR_W);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    if (in_mmio(addr)) begin
      case (addr[7:0])
        8'h04:   return {24'h0, m_rx_buf};
        8'h08:   return {28'h0, m_rx_ovr, m_rx_full, m_tx_cnt == 0, m_tx_cnt == TX_DEPTH};
        default: return 32'h0;
      endcase
    end
    if (!m_ram.exists(word_idx(addr))) return 'x;
    return m_ram[word_idx(addr)];
  endfunction

  // Lane L of the word receives byte (L - offset) mod 4 of the store data.
  function automatic void model_ram_write(input logic [31:0] addr, input logic [3:0] en,
                                          input logic [31:0] din);
    int          off;
    int          src;
    logic [31:0] w;
    off = int'(addr[1:0]);
    w   = m_ram.exists(word_idx(addr)) ? m_ram[word_idx(addr)] : 'x;
    for (int lane = 0; lane < 4; lane++) begin
      if (en[lane]) begin
        src = (lane - off + 4) % 4;
        w[8*lane +: 8] = din[8*src +: 8];
      end
    end
    m_ram[word_idx(addr)] = w;
  endfunction

  // One clock of whatever request is currently driven; called at posedge+2.
  task automatic step(input bit use_k, input logic [31:0] k, output bit accepted);
    bit          is_mmio, exp_hold, pop, push, rx_rd, ovr_clr, ovr_ev;
    logic [7:0]  off;
    logic [31:0] rd_val;
    if (rand_mode) begin
      bus.tx_ready = 1'($urandom_range(0, 1));
      bus.rx_valid = ($urandom_range(0, 5) == 0);
      bus.rx_data  = 8'($urandom);
    end
    is_mmio  = in_mmio(bus.mem_addr);
    off      = bus.mem_addr[7:0];
    exp_hold = bus.mem_wea && is_mmio && off == 8'h00 && m_tx_cnt == TX_DEPTH;
    rd_val   = use_k ? k : model_read(bus.mem_addr);
    pop      = bus.tx_ready && m_tx_cnt > 0;
    @(negedge clk);
    check("mem_hold", {31'h0, bus.mem_hold}, {31'h0, exp_hold});
    @(posedge clk);
    accepted = !exp_hold;
    push = 0; rx_rd = 0; ovr_clr = 0; ovr_ev = 0;
    if (accepted) begin
      if (bus.mem_rea) rd_q.push_back(rd_val);
      push    = bus.mem_wea && is_mmio && off == 8'h00;
      rx_rd   = bus.mem_rea && is_mmio && off == 8'h04;
      ovr_clr = bus.mem_wea && is_mmio && off == 8'h08 && bus.mem_din[3];
      if (push) sb_tx.push_back(bus.mem_din[7:0]);
      if (bus.mem_wea && !is_mmio) model_ram_write(bus.mem_addr, bus.mem_en, bus.mem_din);
    end
    m_tx_cnt = m_tx_cnt + int'(push) - int'(pop);
    if (bus.rx_valid) begin
      if (!m_rx_full || rx_rd) begin
        m_rx_buf  = bus.rx_data;
        m_rx_full = 1;
      end else begin
        ovr_ev = 1;
      end
    end else if (rx_rd) begin
      m_rx_full = 0;
    end
    if (ovr_ev) m_rx_ovr = 1;
    else if (ovr_clr) m_rx_ovr = 0;
    #2;
    bus.rx_valid = 1'b0;
  endtask

  task automatic req(input bit we, input bit re, input logic [3:0] en, input logic [31:0] addr,
                     input logic [31:0] din, input bit use_k = 0, input logic [31:0] k = '0);
    bit acc;
    int n;
    bus.mem_wea  = we;
    bus.mem_rea  = re;
    bus.mem_en   = en;
    bus.mem_addr = addr;
    bus.mem_din  = din;
    n = 0;
    do begin
      step(use_k, k, acc);
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: addr %08h still held after %0d cycles", addr, n);
    end
    bus.mem_wea = 1'b0;
    bus.mem_rea = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    bus.mem_wea = 1'b0;
    bus.mem_rea = 1'b0;
    repeat (n) step(0, '0, acc);
  endtask

  // Monitor: compares load data the cycle after an accepted read, and every TX handshake.
  initial begin : monitor
    bit pend;
    pend = 0;
    forever begin
      @(negedge clk);
      if (pend) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected: mem_dout %08h with no expected load", bus.mem_dout);
        end else begin
          check("mem_dout", bus.mem_dout, rd_q.pop_front());
        end
      end
      pend = bus.mem_rea && !bus.mem_hold && !Rst;
      check("tx_valid", {31'h0, bus.tx_valid}, {31'h0, m_tx_cnt != 0});
      if (bus.tx_valid && bus.tx_ready) begin
        if (sb_tx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: tx_data %02h with no expected byte", bus.tx_data);
        end else begin
          check("tx_data", {24'h0, bus.tx_data}, {24'h0, sb_tx.pop_front()});
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bit acc;
    logic [31:0] a;
    bus.mem_wea  = 1'b0;
    bus.mem_rea  = 1'b0;
    bus.mem_en   = '0;
    bus.mem_addr = '0;
    bus.mem_din  = '0;
    bus.tx_ready = 1'b0;
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    check("rst_mem_dout", bus.mem_dout, 32'h0);
    check("rst_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
    check("rst_tx_data", {24'h0, bus.tx_data}, 32'h0);
    check("rst_mem_hold", {31'h0, bus.mem_hold}, 32'h0);
    Rst = 1'b0;

    // Byte and halfword stores merged into one word
    req(1, 0, 4'hF, 32'h100, 32'h1122_3344);
    req(1, 0, 4'b0010, 32'h101, 32'h0000_00AA);
    req(1, 0, 4'b1100, 32'h102, 32'h0000_BEEF);
    req(0, 1, 4'hF, 32'h100, '0, 1, 32'hBEEF_AA44);

    // Halfword wrapping within the word
    req(1, 0, 4'hF, 32'h200, 32'h0);
    req(1, 0, 4'b1001, 32'h203, 32'h0000_5566);
    req(0, 1, 4'hF, 32'h200, '0, 1, 32'h6600_0055);

    // Read-first on simultaneous write/read
    req(1, 0, 4'hF, 32'h300, 32'h1);
    req(1, 1, 4'hF, 32'h300, 32'h2, 1, 32'h1);
    req(0, 1, 4'hF, 32'h300, '0, 1, 32'h2);

    // TX backpressure: 8 accepted, 9th stalls until one pop
    bus.tx_ready = 1'b0;
    for (int i = 0; i < TX_DEPTH; i++) req(1, 0, 4'hF, MMIO, 32'h10 + i);
    bus.mem_wea  = 1'b1;
    bus.mem_addr = MMIO;
    bus.mem_din  = 32'h18;
    step(0, '0, acc);
    step(0, '0, acc);
    bus.tx_ready = 1'b1;
    step(0, '0, acc);
    bus.tx_ready = 1'b0;
    step(0, '0, acc);
    bus.mem_wea = 1'b0;
    req(0, 1, 4'hF, MMIO + 32'h8, '0, 1, 32'h1);
    bus.tx_ready = 1'b1;
    idle(TX_DEPTH + 2);
    bus.tx_ready = 1'b0;
    check("tx_drained", sb_tx.size(), 0);

    // RX overrun and its clear
    bus.rx_valid = 1'b1; bus.rx_data = 8'h41;
    idle(1);
    bus.rx_valid = 1'b1; bus.rx_data = 8'h42;
    idle(1);
    req(0, 1, 4'hF, MMIO + 32'h4, '0, 1, 32'h41);
    req(0, 1, 4'hF, MMIO + 32'h8, '0);
    req(1, 0, 4'hF, MMIO + 32'h8, 32'h8);
    req(0, 1, 4'hF, MMIO + 32'h8, '0);

    // RX byte arriving during an RXDATA read
    bus.rx_valid = 1'b1; bus.rx_data = 8'h41;
    idle(1);
    bus.rx_valid = 1'b1; bus.rx_data = 8'h43;
    req(0, 1, 4'hF, MMIO + 32'h4, '0, 1, 32'h41);
    req(0, 1, 4'hF, MMIO + 32'h8, '0);
    req(0, 1, 4'hF, MMIO + 32'h4, '0, 1, 32'h43);

    // Randomised mix of RAM (with address aliasing) and MMIO traffic
    for (int w = 0; w < 8; w++) req(1, 0, 4'hF, 32'h400 + 32'(4 * w), $urandom);
    rand_mode = 1;
    for (int n = 0; n < 400; n++) begin
      bit we, re;
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      if (!we && !re) re = 1;
      if ($urandom_range(0, 9) < 6) begin
        a = {1'b0, 17'($urandom), 12'(12'h100 + $urandom_range(0, 7)), 2'($urandom)};
      end else begin
        a = MMIO | 32'(4 * $urandom_range(0, 3));
      end
      req(we, re, 4'($urandom), a, $urandom);
    end
    rand_mode = 0;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    idle(TX_DEPTH + 4);
    bus.tx_ready = 1'b0;

    // Asynchronous reset mid-cycle with a full FIFO, a stalled store and RX pending
    for (int i = 0; i < TX_DEPTH; i++) req(1, 0, 4'hF, MMIO, 32'hA0 + i);
    bus.rx_valid = 1'b1; bus.rx_data = 8'h55;
    idle(1);
    req(0, 1, 4'hF, 32'h100, '0, 1, 32'hBEEF_AA44);
    idle(1);
    bus.mem_wea  = 1'b1;
    bus.mem_addr = MMIO;
    bus.mem_din  = 32'h99;
    #1;
    check("pre_rst_hold", {31'h0, bus.mem_hold}, 32'h1);
    #1;
    Rst = 1'b1;
    m_tx_cnt  = 0;
    m_rx_buf  = '0;
    m_rx_full = 0;
    m_rx_ovr  = 0;
    sb_tx.delete();
    rd_q.delete();
    #1;
    check("arst_mem_dout", bus.mem_dout, 32'h0);
    check("arst_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
    check("arst_tx_data", {24'h0, bus.tx_data}, 32'h0);
    check("arst_mem_hold", {31'h0, bus.mem_hold}, 32'h0);
    bus.mem_wea = 1'b0;
    @(posedge clk);
    #2;
    Rst = 1'b0;
    req(0, 1, 4'hF, MMIO + 32'h8, '0, 1, 32'h2);
    req(0, 1, 4'hF, MMIO + 32'h4, '0, 1, 32'h0);
    idle(2);
    check("rd_q_empty", rd_q.size(), 0);
    check("sb_tx_empty", sb_tx.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
